mux_sel_buf: RTL and testbench

//  Parametrised N-way word selector with a 2-entry output buffer and valid/ready handshake.

---
 rtl/mux_sel_buf.sv | 118 +++++++++++
 tb/tb_mux_sel_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_buf.sv
// N-way word selector feeding a 2-entry registered FIFO with valid/ready handshake.
// Out-of-range select codes replay the last good word and raise a sticky error flag.

module mux_sel_lane #(
  parameter int WIDTH = 18,
  parameter int SEL_W = 3,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] masked
);
  assign masked = (sel == SEL_W'(IDX)) ? word : '0;
endmodule

module mux_sel_buf #(
  parameter int WIDTH  = 18,
  parameter int NUM_IN = 6,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);
  localparam int CW = SEL_W + 1;

  typedef struct packed {
    logic             bad;
    logic [WIDTH-1:0] word;
  } req_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  logic [NUM_IN-1:0][WIDTH-1:0] lane_in, lane_out;
  logic [WIDTH-1:0]             picked, last_good, tail;
  logic                         sel_ok, accept, pop;
  logic                         head_ld, head_from_tail, tail_ld;
  req_t                         req;
  state_t                       state, state_nxt;

  assign lane_in = in_data;

  // Each lane passes its word only when selected; OR-reduce gives the pick.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    mux_sel_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(g)) u_lane (
      .sel    (sel),
      .word   (lane_in[g]),
      .masked (lane_out[g])
    );
  end

  always_comb begin
    picked = '0;
    for (int i = 0; i < NUM_IN; i++) picked |= lane_out[i];
  end

  assign sel_ok   = {1'b0, sel} < CW'(NUM_IN);
  assign req.bad  = !sel_ok;
  assign req.word = sel_ok ? picked : last_good;
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_tail = 1'b0;
    tail_ld        = 1'b0;
    case (state)
      S_EMPTY: if (accept) begin
        state_nxt = S_ONE;
        head_ld   = 1'b1;
      end
      S_ONE: begin
        if (accept && pop) head_ld = 1'b1;
        else if (accept) begin
          tail_ld   = 1'b1;
          state_nxt = S_FULL;
        end else if (pop) state_nxt = S_EMPTY;
      end
      S_FULL: if (pop) begin
        head_from_tail = 1'b1;
        state_nxt      = S_ONE;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state, so no in->out comb path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_data  <= '0;
      tail      <= '0;
      last_good <= '0;
      sel_err   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != S_FULL);
      out_valid <= (state_nxt != S_EMPTY);
      if (head_ld)             out_data <= req.word;
      else if (head_from_tail) out_data <= tail;
      if (tail_ld)             tail <= req.word;
      if (accept && !req.bad)  last_good <= req.word;
      if (accept && req.bad)   sel_err <= 1'b1;
      else if (err_clr)        sel_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_sel_buf.sv
// Bench for mux_sel_buf: directed scenarios plus randomized traffic against a queue model.

module tb_mux_sel_buf;
  localparam int WIDTH  = 18;
  localparam int NUM_IN = 6;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid, in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid, out_ready;
  logic                    sel_err, err_clr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as a queue plus a few scalar flags.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_last_good, m_last_out;
  logic             m_err, m_rdy;

  mux_sel_buf #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic set_ch(input int c, input logic [WIDTH-1:0] v);
    in_data[c*WIDTH +: WIDTH] = v;
  endtask

  task automatic rand_data();
    for (int c = 0; c < NUM_IN; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // One clock edge; the model advances from the same inputs, then outputs settle.
  task automatic cyc();
    logic             acc, pp;
    logic [WIDTH-1:0] w;
    int               s;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_last_good = '0; m_last_out = '0; m_err = 1'b0; m_rdy = 1'b0;
    end else begin
      s   = int'(sel);
      acc = in_valid && m_rdy;
      pp  = (m_q.size() != 0) && out_ready;
      w   = (s < NUM_IN) ? in_data[s*WIDTH +: WIDTH] : m_last_good;
      if (pp) m_last_out = m_q.pop_front();
      if (acc) begin
        m_q.push_back(w);
        if (s < NUM_IN) m_last_good = w;
      end
      if (acc && s >= NUM_IN) m_err = 1'b1;
      else if (err_clr)       m_err = 1'b0;
      m_rdy = (m_q.size() < 2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = '0;
    rand_data();
    cyc(); cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL reset_sel_err got %0b want 0", sel_err); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_select();
    rand_data(); set_ch(2, 18'h2AAAA); sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sel2_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== 18'h2AAAA) begin n_bad++; $display("FAIL sel2_data got %h want 2aaaa", out_data); end
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL sel2_err got %0b want 0", sel_err); end
    cyc();
  endtask

  task automatic test_invalid_sel();
    rand_data(); set_ch(0, 18'h00011); sel = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    n_cmp++; if (out_data !== 18'h00011) begin n_bad++; $display("FAIL inv_first got %h want 00011", out_data); end
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL inv_err_early got %0b want 0", sel_err); end
    rand_data(); sel = 3'd7;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL inv_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== 18'h00011) begin n_bad++; $display("FAIL inv_repeat got %h want 00011", out_data); end
    n_cmp++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL inv_err got %0b want 1", sel_err); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL inv_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
    set_ch(1, 18'd1); cyc();
    set_ch(1, 18'd2); cyc();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got %0b want 0", in_ready); end
    set_ch(1, 18'd3); cyc();
    n_cmp++; if (out_data !== 18'd1) begin n_bad++; $display("FAIL bp_stall_data got %h want 1", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready got %0b want 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    n_cmp++; if (out_data !== 18'd2) begin n_bad++; $display("FAIL bp_second got %h want 2", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_reopen got %0b want 1", in_ready); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_c_dropped got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd4; set_ch(4, 18'd5);
    cyc();
    set_ch(4, 18'd6); out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 18'd6) begin n_bad++; $display("FAIL b2b_data got %h want 6", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %0b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_single got %0b want 0", out_valid); end
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1; in_valid = 1'b0;
    cyc();
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL clr_initial got %0b want 0", sel_err); end
    err_clr = 1'b0; sel = 3'd7;
    cyc();
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL clr_no_accept got %0b want 0", sel_err); end
    sel = 3'd6; in_valid = 1'b1; err_clr = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL clr_set_prio got %0b want 1", sel_err); end
    cyc();
    err_clr = 1'b0;
    n_cmp++; if (sel_err !== 1'b0) begin n_bad++; $display("FAIL clr_alone got %0b want 0", sel_err); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd3; rand_data();
    cyc(); cyc();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mr_full got %0b want 0", in_ready); end
    rst_n = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL mr_data got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready got %0b want 0", in_ready); end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mr_release got %0b want 1", in_ready); end
    rand_data(); set_ch(1, 18'h3FFFF); sel = 3'd1; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 18'h3FFFF) begin n_bad++; $display("FAIL mr_first got %h want 3ffff", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mr_first_valid got %0b want 1", out_valid); end
    cyc();
  endtask

  task automatic test_random();
    logic             mv;
    logic [WIDTH-1:0] md;
    for (int i = 0; i < 600; i++) begin
      rand_data();
      sel       = SEL_W'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 59) != 0);
      cyc();
      mv = (m_q.size() != 0);
      md = mv ? m_q[0] : m_last_out;
      n_cmp++; if (out_valid !== mv) begin n_bad++; $display("FAIL rnd_valid i=%0d got %0b want %0b", i, out_valid, mv); end
      n_cmp++; if (out_data !== md) begin n_bad++; $display("FAIL rnd_data i=%0d got %h want %h", i, out_data, md); end
      n_cmp++; if (in_ready !== m_rdy) begin n_bad++; $display("FAIL rnd_ready i=%0d got %0b want %0b", i, in_ready, m_rdy); end
      n_cmp++; if (sel_err !== m_err) begin n_bad++; $display("FAIL rnd_err i=%0d got %0b want %0b", i, sel_err, m_err); end
    end
    rst_n = 1'b1; in_valid = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_select();
    test_invalid_sel();
    test_backpressure();
    test_back_to_back();
    test_err_clr();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
